// File: rtl/sha_result_collector.sv
// SHA-256 result collector: target compare, winning-nonce FIFO, hash/hit counters.
// Optional macro SHA_COLLECT_CMP_PIPE_EN adds a register stage ahead of the compare.
module sha_result_collector #(
  parameter int WORD_S     = 32,
  parameter int H_SIZE     = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [H_SIZE-1:0]             H,
  input  logic [WORD_S-1:0]             nonce,
  input  logic [H_SIZE-1:0]             target,
  input  logic                          clear,
  output logic                          found_valid,
  input  logic                          found_ready,
  output logic [WORD_S-1:0]             found_nonce,
  output logic [H_SIZE-1:0]             found_hash,
  output logic [CNT_W-1:0]              hash_count,
  output logic [CNT_W-1:0]              hit_count,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = WORD_S + H_SIZE;

  logic              stb_en;
  logic [H_SIZE-1:0] stb_h;
  logic [H_SIZE-1:0] stb_tgt;
  logic [WORD_S-1:0] stb_nonce;

`ifdef SHA_COLLECT_CMP_PIPE_EN
  logic              p_en_q, p_en_d;
  logic [H_SIZE-1:0] p_h_q, p_h_d, p_tgt_q, p_tgt_d;
  logic [WORD_S-1:0] p_nonce_q, p_nonce_d;

  always_comb begin
    p_en_d    = en & ~clear;
    p_h_d     = H;
    p_tgt_d   = target;
    p_nonce_d = nonce;
  end

  always_ff @(posedge clk) begin
    if (reset) p_en_q <= 1'b0;
    else       p_en_q <= p_en_d;
  end

  always_ff @(posedge clk) begin
    p_h_q     <= p_h_d;
    p_tgt_q   <= p_tgt_d;
    p_nonce_q <= p_nonce_d;
  end

  assign stb_en    = p_en_q;
  assign stb_h     = p_h_q;
  assign stb_tgt   = p_tgt_q;
  assign stb_nonce = p_nonce_q;
`else
  assign stb_en    = en;
  assign stb_h     = H;
  assign stb_tgt   = target;
  assign stb_nonce = nonce;
`endif

  // Digest is compared as a little-endian number, hence the byte reversal.
  logic [H_SIZE-1:0] cmp;
  logic              hit_now;
  always_comb begin
    cmp = '0;
    for (int i = 0; i < H_SIZE/8; i++) cmp[8*i +: 8] = stb_h[H_SIZE-8-8*i +: 8];
    hit_now = (cmp <= stb_tgt);
  end

  logic              s1_vld_q, s1_vld_d, s1_hit_q, s1_hit_d;
  logic [H_SIZE-1:0] s1_h_q, s1_h_d;
  logic [WORD_S-1:0] s1_nonce_q, s1_nonce_d;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  hash_cnt_q, hash_cnt_d, hit_cnt_q, hit_cnt_d;
  logic              ovf_q, ovf_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];

  logic [LW-1:0] level;
  logic          push, pop, full;
  logic [EW-1:0] head;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == LW'(FIFO_DEPTH));
  assign push  = s1_vld_q & s1_hit_q;
  assign pop   = found_valid & found_ready;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    s1_vld_d   = stb_en & ~clear;
    s1_hit_d   = hit_now;
    s1_h_d     = stb_h;
    s1_nonce_d = stb_nonce;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hash_cnt_d = hash_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    ovf_d      = ovf_q;
    mem_d      = mem_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      hash_cnt_d = '0;
      hit_cnt_d  = '0;
      ovf_d      = 1'b0;
    end else begin
      if (stb_en) hash_cnt_d = hash_cnt_q + CNT_W'(1);
      if (push) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (!full || pop) begin
          mem_d[wr_ptr_q[AW-1:0]] = {s1_nonce_q, s1_h_q};
          wr_ptr_d = wr_ptr_q + LW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hash_cnt_q <= '0;
      hit_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hash_cnt_q <= hash_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_hit_q   <= s1_hit_d;
    s1_h_q     <= s1_h_d;
    s1_nonce_q <= s1_nonce_d;
    mem_q      <= mem_d;
  end

  // Head data is forced to zero while empty so reset values are defined.
  assign found_valid = (level != '0);
  assign found_nonce = found_valid ? head[EW-1:H_SIZE] : '0;
  assign found_hash  = found_valid ? head[H_SIZE-1:0]  : '0;
  assign hash_count  = hash_cnt_q;
  assign hit_count   = hit_cnt_q;
  assign overflow    = ovf_q;
  assign fifo_level  = level;

endmodule
